// File: rtl/ulpi_hs_negotiator.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_hs_negotiator
// Purpose  : Device-side USB 2.0 high-speed detection handshake over ULPI.
//            Programs the PHY, waits out bus reset, drives chirp-K, counts
//            host K/J chirp pairs and settles in HS, FS fallback or FAIL.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_hs_negotiator #(
    parameter int TICK_DIV           = 6,
    parameter int CNT_W              = 17,
    parameter int STARTUP_TICKS      = 65000,
    parameter int SE0_TICKS          = 25,
    parameter int CHIRP_K_TICKS      = 20000,
    parameter int JK_TICKS           = 30,
    parameter int JK_PAIRS           = 3,
    parameter int HOST_TIMEOUT_TICKS = 20000,
    parameter int MAX_RETRY          = 2
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       START,
    input  logic       ULPI_READY,
    input  logic [7:0] RXCMD,
    output logic       REG_EN,
    output logic       REG_RW,
    output logic [5:0] REG_ADDR,
    output logic [7:0] REG_DATA,
    input  logic       REG_DONE,
    input  logic       REG_FAIL,
    output logic       TX_START_END,
    input  logic       TX_FAIL,
    output logic       HS_MODE,
    output logic       FS_MODE,
    output logic       BUSY,
    output logic       FAIL,
    output logic [7:0] STATE
);

    typedef enum logic [7:0] {
        S_IDLE     = 8'd0,
        S_WR_OTG   = 8'd1,
        S_STARTUP  = 8'd2,
        S_WR_FS    = 8'd3,
        S_DET_SE0  = 8'd4,
        S_WR_CHIRP = 8'd5,
        S_CHIRP_K  = 8'd6,
        S_DET_K    = 8'd7,
        S_DET_J    = 8'd8,
        S_WR_HS    = 8'd9,
        S_HS_DONE  = 8'd10,
        S_WR_FS_FB = 8'd11,
        S_FS_DONE  = 8'd12,
        S_FAIL     = 8'h55
    } state_t;

    localparam int               c_DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_div_last = c_DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_startup    = CNT_W'(STARTUP_TICKS);
    localparam logic [CNT_W-1:0] c_se0        = CNT_W'(SE0_TICKS);
    localparam logic [CNT_W-1:0] c_chirp      = CNT_W'(CHIRP_K_TICKS);
    localparam logic [CNT_W-1:0] c_jk         = CNT_W'(JK_TICKS);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(HOST_TIMEOUT_TICKS);
    localparam logic [7:0]       c_pairs      = 8'(JK_PAIRS);
    localparam logic [7:0]       c_max_retry  = 8'(MAX_RETRY);

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_ls;
    logic [CNT_W-1:0]   r_tcnt;
    logic [CNT_W-1:0]   r_host;
    logic [7:0]         r_pair;
    logic [7:0]         r_retry;
    logic               r_reg_en;
    logic               r_reg_rw;
    logic [5:0]         r_reg_addr;
    logic [7:0]         r_reg_data;
    logic               r_tx;
    logic               r_hs;
    logic               r_fs;
    logic               r_busy;
    logic               r_fail;

    state_t             w_next;
    logic               w_tick;
    logic               w_clr;
    logic               w_chirp_end;
    logic               w_retry_inc;
    logic               w_pair_inc;
    logic               w_restart;
    logic               w_host_run;
    logic               w_wr;
    logic [5:0]         w_addr;
    logic [7:0]         w_data;
    logic               w_unused_rxcmd;

    // Only LineState is consumed; the remaining RXCMD bits are deliberately ignored.
    assign w_unused_rxcmd = ^RXCMD[7:2];

    assign w_tick     = (r_div == c_div_last);
    assign w_host_run = (r_state == S_DET_K) || (r_state == S_DET_J);

    // Free-running tick divider.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Single register stage on LineState before any decision uses it.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            r_ls <= 2'b00;
        end else begin
            r_ls <= RXCMD[1:0];
        end
    end

    // Next-state decision and the side effects that accompany each transition.
    always_comb begin
        w_next      = r_state;
        w_clr       = 1'b0;
        w_chirp_end = 1'b0;
        w_retry_inc = 1'b0;
        w_pair_inc  = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) w_next = S_WR_OTG;
            end
            S_WR_OTG: begin
                if (REG_FAIL)      w_next = S_FAIL;
                else if (REG_DONE) w_next = S_STARTUP;
            end
            S_STARTUP: begin
                if (r_tcnt >= c_startup) w_next = S_WR_FS;
            end
            S_WR_FS: begin
                if (REG_FAIL)      w_next = S_FAIL;
                else if (REG_DONE) w_next = S_DET_SE0;
            end
            S_DET_SE0: begin
                if (!((r_ls == 2'b00) && ULPI_READY)) w_clr  = 1'b1;
                else if (r_tcnt > c_se0)              w_next = S_WR_CHIRP;
            end
            S_WR_CHIRP: begin
                if (REG_FAIL)      w_next = S_FAIL;
                else if (REG_DONE) w_next = S_CHIRP_K;
            end
            S_CHIRP_K: begin
                // A transmit failure aborts the chirp; retry from bus-reset detection.
                if (TX_FAIL) begin
                    if (r_retry < c_max_retry) begin
                        w_retry_inc = 1'b1;
                        w_next      = S_DET_SE0;
                    end else begin
                        w_next = S_FAIL;
                    end
                end else if (r_tcnt >= c_chirp) begin
                    w_chirp_end = 1'b1;
                    w_next      = S_DET_K;
                end
            end
            S_DET_K: begin
                if (r_host >= c_timeout) w_next = S_WR_FS_FB;
                else if (r_ls != 2'b10)  w_clr  = 1'b1;
                else if (r_tcnt > c_jk)  w_next = S_DET_J;
            end
            S_DET_J: begin
                // Timeout wins even if the final J completes on the same cycle.
                if (r_host >= c_timeout) begin
                    w_next = S_WR_FS_FB;
                end else if (r_ls != 2'b01) begin
                    w_clr = 1'b1;
                end else if (r_tcnt > c_jk) begin
                    w_pair_inc = 1'b1;
                    w_next     = ((r_pair + 8'd1) == c_pairs) ? S_WR_HS : S_DET_K;
                end
            end
            S_WR_HS: begin
                if (REG_FAIL)      w_next = S_FAIL;
                else if (REG_DONE) w_next = S_HS_DONE;
            end
            S_WR_FS_FB: begin
                if (REG_FAIL)      w_next = S_FAIL;
                else if (REG_DONE) w_next = S_FS_DONE;
            end
            S_HS_DONE, S_FS_DONE, S_FAIL: begin
                if (START) begin
                    w_restart = 1'b1;
                    w_next    = S_WR_OTG;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Register-write payload for the state being entered.
    always_comb begin
        w_wr   = 1'b1;
        w_addr = 6'h04;
        w_data = 8'h00;
        case (w_next)
            S_WR_OTG:            begin w_addr = 6'h0A; w_data = 8'h00; end
            S_WR_FS, S_WR_FS_FB: begin w_data = 8'h45; end
            S_WR_CHIRP:          begin w_data = 8'h54; end
            S_WR_HS:             begin w_data = 8'h40; end
            default:             begin w_wr = 1'b0; w_addr = 6'h00; end
        endcase
    end

    // FSM state, timers, counters and registered outputs.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            r_state    <= S_IDLE;
            r_tcnt     <= '0;
            r_host     <= '0;
            r_pair     <= '0;
            r_retry    <= '0;
            r_reg_en   <= 1'b0;
            r_reg_rw   <= 1'b0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_tx       <= 1'b0;
            r_hs       <= 1'b0;
            r_fs       <= 1'b0;
            r_busy     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state <= w_next;

            // Tick counter restarts on every state entry and on a line-state violation.
            if ((w_next != r_state) || w_clr) begin
                r_tcnt <= '0;
            end else if (w_tick && (r_tcnt != '1)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_chirp_end) begin
                r_host <= '0;
            end else if (w_host_run && w_tick && (r_host != '1)) begin
                r_host <= r_host + 1'b1;
            end

            if (w_restart) begin
                r_retry <= '0;
                r_pair  <= '0;
            end else begin
                if (w_retry_inc) r_retry <= r_retry + 8'd1;
                if (w_chirp_end)     r_pair <= '0;
                else if (w_pair_inc) r_pair <= r_pair + 8'd1;
            end

            r_reg_en   <= w_wr;
            r_reg_rw   <= w_wr;
            r_reg_addr <= w_addr;
            r_reg_data <= w_data;
            // Strobe on the first chirp-K cycle and again when the chirp ends.
            r_tx       <= w_chirp_end || ((w_next == S_CHIRP_K) && (r_state != S_CHIRP_K));
            r_hs       <= (w_next == S_HS_DONE);
            r_fs       <= (w_next == S_FS_DONE);
            r_fail     <= (w_next == S_FAIL);
            r_busy     <= !((w_next == S_IDLE) || (w_next == S_HS_DONE) ||
                            (w_next == S_FS_DONE) || (w_next == S_FAIL));
        end
    end

    assign REG_EN       = r_reg_en;
    assign REG_RW       = r_reg_rw;
    assign REG_ADDR     = r_reg_addr;
    assign REG_DATA     = r_reg_data;
    assign TX_START_END = r_tx;
    assign HS_MODE      = r_hs;
    assign FS_MODE      = r_fs;
    assign BUSY         = r_busy;
    assign FAIL         = r_fail;
    assign STATE        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_hs_negotiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_hs_negotiator
// Purpose  : Directed self-checking bench for ulpi_hs_negotiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_hs_negotiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ulpi_ready = 1'b1;
    logic [7:0] rxcmd = 8'h00;
    logic       reg_done = 1'b0;
    logic       reg_fail = 1'b0;
    logic       tx_fail = 1'b0;

    logic       REG_EN, REG_RW, TX_START_END, HS_MODE, FS_MODE, BUSY, FAIL;
    logic [5:0] REG_ADDR;
    logic [7:0] REG_DATA, STATE;

    always #5 clk = ~clk;

    ulpi_hs_negotiator #(
        .TICK_DIV(6), .CNT_W(17), .STARTUP_TICKS(10), .SE0_TICKS(5),
        .CHIRP_K_TICKS(20), .JK_TICKS(3), .JK_PAIRS(3),
        .HOST_TIMEOUT_TICKS(200), .MAX_RETRY(1)
    ) dut (
        .CLK_60M(clk), .NRST_A_USB(rst_n), .START(start), .ULPI_READY(ulpi_ready),
        .RXCMD(rxcmd), .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR),
        .REG_DATA(REG_DATA), .REG_DONE(reg_done), .REG_FAIL(reg_fail),
        .TX_START_END(TX_START_END), .TX_FAIL(tx_fail), .HS_MODE(HS_MODE),
        .FS_MODE(FS_MODE), .BUSY(BUSY), .FAIL(FAIL), .STATE(STATE)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          tx_cnt = 0;
    int          rw_bad = 0;
    int          wait_cnt = 0;
    int          n40;
    logic        saw_detj = 1'b0;
    logic        fail_fs = 1'b0;
    logic [13:0] wlog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [7:0] s, input int budget);
        int k = 0;
        while (STATE !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, STATE, s);
    endtask

    // Register-port responder (3-cycle write latency) and output monitor.
    initial begin
        forever begin
            @(negedge clk);
            reg_done = 1'b0;
            reg_fail = 1'b0;
            if (TX_START_END) tx_cnt++;
            if (STATE == 8'd8) saw_detj = 1'b1;
            if (REG_EN !== REG_RW) rw_bad++;
            if (REG_EN && rst_n) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    wlog.push_back({REG_ADDR, REG_DATA});
                    if (fail_fs && REG_ADDR == 6'h04 && REG_DATA == 8'h45) reg_fail = 1'b1;
                    else reg_done = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        // Reset state
        cyc(3);
        chk("rst_state", STATE, 8'd0);
        chk("rst_reg_en", REG_EN, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_status", {HS_MODE, FS_MODE, FAIL, TX_START_END}, 4'b0000);
        rst_n = 1'b1;
        cyc(2);

        // Happy path: three K/J pairs of 5 ticks each
        wlog.delete();
        tx_cnt = 0;
        pulse_start();
        chk("hp_wr_otg", STATE, 8'd1);
        chk("hp_busy", BUSY, 1'b1);
        wait_state("hp_det_k", 8'd7, 400);
        repeat (3) begin
            rxcmd = 8'h02;
            cyc(30);
            rxcmd = 8'h01;
            cyc(30);
        end
        rxcmd = 8'h00;
        wait_state("hp_hs_done", 8'd10, 20);
        chk("hp_nwrites", wlog.size(), 4);
        chk("hp_w0", wlog[0], {6'h0A, 8'h00});
        chk("hp_w1", wlog[1], {6'h04, 8'h45});
        chk("hp_w2", wlog[2], {6'h04, 8'h54});
        chk("hp_w3", wlog[3], {6'h04, 8'h40});
        chk("hp_tx_pulses", tx_cnt, 2);
        chk("hp_hs_mode", HS_MODE, 1'b1);
        chk("hp_busy_done", BUSY, 1'b0);

        // Restart from HS_DONE, SE0 glitch, short K, then host silent
        wlog.delete();
        tx_cnt = 0;
        saw_detj = 1'b0;
        pulse_start();
        chk("rs_wr_otg", STATE, 8'd1);
        chk("rs_hs_cleared", HS_MODE, 1'b0);
        wait_state("g_det_se0", 8'd4, 200);
        cyc(24);
        rxcmd = 8'h01;
        cyc(1);
        rxcmd = 8'h00;
        cyc(29);
        chk("g_se0_restart", STATE, 8'd4);
        wait_state("g_wr_chirp", 8'd5, 20);
        wait_state("sk_det_k", 8'd7, 200);
        rxcmd = 8'h02;
        cyc(12);
        rxcmd = 8'h00;
        cyc(30);
        chk("sk_state", STATE, 8'd7);
        chk("sk_no_det_j", saw_detj, 1'b0);
        wait_state("to_fs_done", 8'd12, 1400);
        chk("to_nwrites", wlog.size(), 4);
        chk("to_w3", wlog[3], {6'h04, 8'h45});
        n40 = 0;
        foreach (wlog[i]) if (wlog[i] == {6'h04, 8'h40}) n40++;
        chk("to_no_hs_write", n40, 0);
        chk("to_fs_mode", FS_MODE, 1'b1);
        chk("to_hs_mode", HS_MODE, 1'b0);
        chk("to_tx_pulses", tx_cnt, 2);

        // TX_FAIL in CHIRP_K: one retry, then FAIL
        pulse_start();
        chk("tf_wr_otg", STATE, 8'd1);
        chk("tf_fs_cleared", FS_MODE, 1'b0);
        wait_state("tf_chirp1", 8'd6, 300);
        cyc(3);
        tx_fail = 1'b1;
        cyc(1);
        tx_fail = 1'b0;
        chk("tf_retry_se0", STATE, 8'd4);
        wait_state("tf_chirp2", 8'd6, 100);
        cyc(3);
        tx_fail = 1'b1;
        cyc(1);
        tx_fail = 1'b0;
        chk("tf_fail_state", STATE, 8'h55);
        chk("tf_fail_flag", FAIL, 1'b1);
        chk("tf_busy", BUSY, 1'b0);
        pulse_start();
        chk("tf_restart", STATE, 8'd1);
        chk("tf_fail_cleared", FAIL, 1'b0);

        // REG_FAIL on the WR_FS write
        fail_fs = 1'b1;
        wait_state("rf_fail_state", 8'h55, 200);
        chk("rf_fail_flag", FAIL, 1'b1);
        fail_fs = 1'b0;

        // Asynchronous reset during a write, then during CHIRP_K
        pulse_start();
        chk("ar_wr_en", REG_EN, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_wr_en_drop", REG_EN, 1'b0);
        chk("ar_wr_state", STATE, 8'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pulse_start();
        wait_state("ar_chirp", 8'd6, 300);
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", STATE, 8'd0);
        chk("ar_busy", BUSY, 1'b0);
        chk("ar_outputs", {REG_EN, REG_RW, TX_START_END, HS_MODE, FS_MODE, FAIL}, 6'b000000);
        chk("ar_reg_bus", {REG_ADDR, REG_DATA}, 14'h0000);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        chk("reg_rw_tracks_en", rw_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
